// File: rtl/clk_ctrl_pkg.sv
// clk_ctrl_pkg: command encodings, FSM states and ratio limits shared by the clock-control sequencer
package clk_ctrl_pkg;
  typedef enum logic [2:0] {
    CMD_READ  = 3'd0,
    CMD_WRITE = 3'd1,
    CMD_SLOW  = 3'd2,
    CMD_STOP  = 3'd3,
    CMD_RUN   = 3'd4
  } cmd_e;
  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, QUIESCE, GAP, RESP} state_e;
  localparam logic [2:0] RATIO_MIN = 3'd1;
  localparam logic [2:0] RATIO_MAX = 3'd7;
  function automatic logic cmd_legal(input logic [2:0] cmd, input logic [2:0] ratio);
    return (cmd <= CMD_RUN) && !(cmd == CMD_WRITE && !(ratio inside {[RATIO_MIN:RATIO_MAX]}));
  endfunction
endpackage

// File: rtl/clk_ctrl_apb_if.sv
// clk_ctrl_apb_if: single APB transfer engine (SETUP/ACCESS/timeout)
// Ports: start_i launches a transfer (psel rises next cycle); done_o pulses combinationally in the
// final ACCESS cycle with err_o set on timeout and rdata_o carrying prdata[3:0]; APB pins registered.
module clk_ctrl_apb_if
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       write_i,
  input  logic [2:0] wdata_i,
  output logic       done_o,
  output logic       err_o,
  output logic [3:0] rdata_o,
  output logic       psel_o,
  output logic       penable_o,
  output logic       pwrite_o,
  output logic [2:0] pwdata_o,
  input  logic [3:0] prdata_i,
  input  logic       pready_i
);
  logic       psel_q, penable_q, pwrite_q;
  logic [2:0] pwdata_q;
  logic [3:0] cnt_q;
  // The last permitted ACCESS cycle ends the transfer whether or not the target answered.
  assign done_o    = penable_q & (pready_i | cnt_q == 4'd1);
  assign err_o     = ~pready_i;
  assign rdata_o   = prdata_i;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign pwdata_o  = pwdata_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      cnt_q     <= '0;
    end else if (start_i) begin
      psel_q    <= 1'b1;
      penable_q <= 1'b0;
      pwrite_q  <= write_i;
      pwdata_q  <= write_i ? wdata_i : 3'd0;
    end else if (psel_q & ~penable_q) begin
      penable_q <= 1'b1;
      cnt_q     <= 4'(TIMEOUT_CYC);
    end else if (done_o) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else if (penable_q)
      cnt_q <= cnt_q - 4'd1;
endmodule

// File: rtl/clk_ctrl_seq.sv
// clk_ctrl_seq: command sequencer driving clk_gen's APB ratio register and its two gate enables
// Ports: req_* valid/ready command port; rsp_* one-cycle response; psel/penable/pwrite/pwdata/prdata/pready
// APB initiator; gate_en0 (SLOW) and gate_en1 (STOP) mutually exclusive gate requests.
module clk_ctrl_seq
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned QUIESCE_CYC = 4,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic        i_pad_clk,
  input  logic        clkrst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_cmd,
  input  logic [2:0]  req_ratio,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [3:0]  rsp_data,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [2:0]  pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  output logic        gate_en0,
  output logic        gate_en1
);
  state_e     state_q;
  logic [2:0] cmd_q;
  logic [3:0] cnt_q;
  logic       g0_q, g1_q, rsp_err_q;
  logic [3:0] rsp_data_q;
  logic       legal, apb_start, apb_done, apb_err, any_on, tgt_on;
  logic [3:0] apb_rdata;
  logic       unused_prdata;
  assign unused_prdata = ^prdata[31:4];
  assign req_ready = (state_q == IDLE) & ~clkrst;
  assign rsp_valid = state_q == RESP;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign gate_en0  = g0_q;
  assign gate_en1  = g1_q;
  assign legal     = cmd_legal(req_cmd, req_ratio);
  // Launch in the accept cycle so psel is up in the very next cycle.
  assign apb_start = req_valid & req_ready & legal & (req_cmd == CMD_READ | req_cmd == CMD_WRITE);
  assign any_on    = g0_q | g1_q;
  assign tgt_on    = req_cmd == CMD_SLOW ? g0_q : g1_q;
  clk_ctrl_apb_if #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_apb (
    .clk_i     (i_pad_clk),
    .rst_i     (clkrst),
    .start_i   (apb_start),
    .write_i   (req_cmd == CMD_WRITE),
    .wdata_i   (req_ratio),
    .done_o    (apb_done),
    .err_o     (apb_err),
    .rdata_o   (apb_rdata),
    .psel_o    (psel),
    .penable_o (penable),
    .pwrite_o  (pwrite),
    .pwdata_o  (pwdata),
    .prdata_i  (prdata[3:0]),
    .pready_i  (pready)
  );
  always_ff @(posedge i_pad_clk or posedge clkrst)
    if (clkrst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      cnt_q      <= '0;
      g0_q       <= 1'b0;
      g1_q       <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (req_valid) begin
            cmd_q <= req_cmd;
            if (!legal) begin
              rsp_err_q <= 1'b1;
              state_q   <= RESP;
            end else if (req_cmd == CMD_READ || req_cmd == CMD_WRITE)
              state_q <= SETUP;
            else if (req_cmd == CMD_RUN ? !any_on : tgt_on)
              state_q <= RESP;
            else if (any_on) begin
              g0_q    <= 1'b0;
              g1_q    <= 1'b0;
              cnt_q   <= 4'(GAP_CYC);
              state_q <= GAP;
            end else begin
              cnt_q   <= 4'(QUIESCE_CYC);
              state_q <= QUIESCE;
            end
          end
        SETUP: state_q <= ACCESS;
        ACCESS:
          if (apb_done) begin
            state_q    <= RESP;
            rsp_err_q  <= apb_err;
            rsp_data_q <= (cmd_q == CMD_READ && !apb_err) ? apb_rdata : 4'd0;
          end
        // The counter parks at 1 for one extra cycle while the target gate rises,
        // so the response always follows the gate edge by a cycle.
        QUIESCE, GAP:
          if (cnt_q != 4'd1)
            cnt_q <= cnt_q - 4'd1;
          else if (cmd_q == CMD_SLOW && !g0_q)
            g0_q <= 1'b1;
          else if (cmd_q == CMD_STOP && !g1_q)
            g1_q <= 1'b1;
          else
            state_q <= RESP;
        RESP: begin
          state_q    <= IDLE;
          rsp_err_q  <= 1'b0;
          rsp_data_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_clk_ctrl_seq.sv
// tb_clk_ctrl_seq: randomized command stream checked against a latency/gate-timeline model
module tb_clk_ctrl_seq;
  localparam int Q = 4, G = 2, TO = 15;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_cmd = '0, req_ratio = '0;
  logic        rsp_valid, rsp_err;
  logic [3:0]  rsp_data;
  logic        psel, penable, pwrite;
  logic [2:0]  pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        gate_en0, gate_en1;
  int          n_chk = 0, n_fail = 0;
  int          act = 0;
  clk_ctrl_seq #(.QUIESCE_CYC(Q), .GAP_CYC(G), .TIMEOUT_CYC(TO)) dut (
    .i_pad_clk(clk), .clkrst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_ratio(req_ratio), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .gate_en0(gate_en0), .gate_en1(gate_en1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run_cmd(input logic [2:0] cmd, input logic [2:0] ratio, input int waits, input logic [31:0] prd);
    int lat, nact, ea;
    bit legal, apb, wr, err;
    logic [3:0] data;
    legal = cmd <= 4 && !(cmd == 1 && ratio == 0);
    apb = legal && cmd <= 1;
    wr = cmd == 1;
    nact = act;
    err = 0;
    if (!legal) begin
      lat = 1;
      err = 1;
    end else if (apb) begin
      lat = waits >= TO ? TO + 2 : waits + 3;
      err = waits >= TO;
    end else if (cmd == 4) begin
      nact = 0;
      lat = act != 0 ? G + 1 : 1;
    end else begin
      nact = cmd - 1;
      lat = act == nact ? 1 : (act != 0 ? G + 2 : Q + 2);
    end
    data = (apb && !wr && !err) ? prd[3:0] : 4'd0;
    @(negedge clk);
    chk("req_ready idle", req_ready, 1);
    req_valid = 1'b1;
    req_cmd = cmd;
    req_ratio = ratio;
    prdata = prd;
    for (int c = 1; c <= lat + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) req_valid = 1'b0;
      pready = c >= 2 && c - 2 >= waits;
      @(negedge clk);
      ea = (nact == act) ? act : (c >= lat - 1 ? nact : 0);
      chk($sformatf("rsp_valid cmd%0d c%0d", cmd, c), rsp_valid, c == lat);
      chk($sformatf("rsp_err cmd%0d c%0d", cmd, c), rsp_err, c == lat ? err : 1'b0);
      chk($sformatf("rsp_data cmd%0d c%0d", cmd, c), rsp_data, c == lat ? data : 4'd0);
      chk($sformatf("req_ready cmd%0d c%0d", cmd, c), req_ready, c > lat);
      chk($sformatf("gates cmd%0d c%0d", cmd, c), {gate_en1, gate_en0}, {ea == 2, ea == 1});
      chk($sformatf("psel cmd%0d c%0d", cmd, c), psel, apb && c < lat);
      chk($sformatf("penable cmd%0d c%0d", cmd, c), penable, apb && c >= 2 && c < lat);
      if (apb && c < lat)
        chk($sformatf("pwr cmd%0d c%0d", cmd, c), {pwrite, pwdata}, {wr, wr ? ratio : 3'd0});
    end
    pready = 1'b0;
    act = nact;
  endtask
  initial begin
    #1;
    chk("reset outs", {psel, penable, pwrite, pwdata, gate_en0, gate_en1, rsp_valid, rsp_err, rsp_data, req_ready}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", req_ready, 1);
    run_cmd(3'd1, 3'd3, 0, 32'h0);
    run_cmd(3'd0, 3'd0, 2, 32'h0000_0005);
    run_cmd(3'd1, 3'd0, 0, 32'h0);
    run_cmd(3'd6, 3'd2, 0, 32'h0);
    run_cmd(3'd0, 3'd0, 40, 32'hA);
    run_cmd(3'd2, 3'd0, 0, 32'h0);
    run_cmd(3'd2, 3'd0, 0, 32'h0);
    run_cmd(3'd3, 3'd0, 0, 32'h0);
    run_cmd(3'd4, 3'd0, 0, 32'h0);
    run_cmd(3'd4, 3'd0, 0, 32'h0);
    for (int i = 0; i < 80; i++)
      run_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 7) == 0 ? 20 : int'($urandom_range(0, 3)), $urandom);
    run_cmd(3'd3, 3'd0, 0, 32'h0);
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd = 3'd0;
    pready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid access", {psel, penable, gate_en1}, 3'b111);
    #2 rst = 1'b1;
    #1 chk("async reset outs", {psel, penable, pwrite, pwdata, gate_en0, gate_en1, rsp_valid, rsp_err, rsp_data, req_ready}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("no rsp in reset", rsp_valid, 0);
    end
    rst = 1'b0;
    act = 0;
    @(negedge clk);
    chk("post reset", {req_ready, rsp_valid, gate_en0, gate_en1, psel}, 5'b10000);
    run_cmd(3'd2, 3'd0, 0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
